// File: rtl/digits_to_number.sv
// digits_to_number: converts up to MAX_DIGITS BCD digits (MSD first) to a saturating 16-bit binary value
module digits_to_number #(
    parameter int MAX_DIGITS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*MAX_DIGITS-1:0] digits_flat,
    input  logic [3:0]              num_digits,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [15:0]             number,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overflow,
    output logic                    bad_digit
);
    localparam logic [3:0] MAXD = 4'(MAX_DIGITS);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [4*MAX_DIGITS-1:0] digs;
    logic [3:0]              cnt;
    logic [3:0]              n_in;
    logic [3:0]              dig;
    logic [3:0]              dig_ok;
    logic [19:0]             step;
    logic                    hs;

    // Digits are pre-aligned so the current most significant digit always sits in the top slot.
    assign n_in      = (num_digits > MAXD) ? MAXD : num_digits;
    assign hs        = in_valid && (state == IDLE);
    assign dig       = digs[4*MAX_DIGITS-1 -: 4];
    assign dig_ok    = (dig > 4'd9) ? 4'd0 : dig;
    assign step      = 20'(number) * 20'd10 + 20'(dig_ok);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: accept in IDLE, one digit per CONV cycle, hold result in DONE
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid) state_nxt = (n_in == 4'd0) ? DONE : CONV;
            CONV:    if (cnt == 4'd1) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture request, then accumulate acc*10+d with sticky saturation and bad-digit flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digs      <= '0;
            cnt       <= '0;
            number    <= '0;
            overflow  <= 1'b0;
            bad_digit <= 1'b0;
        end else if (hs) begin
            digs      <= digits_flat << (4 * (MAX_DIGITS - int'(n_in)));
            cnt       <= n_in;
            number    <= '0;
            overflow  <= 1'b0;
            bad_digit <= 1'b0;
        end else if (state == CONV) begin
            digs      <= digs << 4;
            cnt       <= cnt - 4'd1;
            bad_digit <= bad_digit | (dig > 4'd9);
            if (overflow || step > 20'hFFFF) begin
                number   <= 16'hFFFF;
                overflow <= 1'b1;
            end else begin
                number   <= step[15:0];
            end
        end
    end
endmodule
